// File: rtl/uart_rx_byte.sv
// Oversampling UART receiver: serial line in, byte plus one-clock done strobe out.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking; the default build receives 8N1.
module uart_rx_byte #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] DIV_LAST  = TW'(DIV - 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd5;
`endif

    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [SW-1:0] sample_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
`ifdef UART_RX_PARITY_EN
    logic          parity_bad;
`endif

    // Synchronisers reset to 1 so that leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == DIV_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
`endif
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state      <= S_START;
                        sample_cnt <= '0;
                        rx_busy    <= 1'b1;
                    end
                end
                // A start bit that is high again at its midpoint was only a glitch.
                S_START: begin
                    if (tick) begin
                        if (sample_cnt == HALF_LAST) begin
                            if (!rx_s) begin
                                sample_cnt <= '0;
                                bit_idx    <= '0;
                                state      <= S_DATA;
                            end else begin
                                state   <= S_IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt         <= '0;
                            shift_reg[bit_idx] <= rx_s;
                            bit_idx            <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            parity_bad <= (rx_s != ^shift_reg);
                            parity_err <= (rx_s != ^shift_reg);
                            state      <= S_STOP;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
`endif
                // Returning to IDLE right at the stop-bit midpoint leaves half a bit to catch the next start edge.
                S_STOP: begin
                    if (tick) begin
                        if (sample_cnt == FULL_LAST) begin
                            sample_cnt <= '0;
                            if (rx_s) begin
                                state   <= S_IDLE;
                                rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                if (!parity_bad) begin
                                    rx_data <= shift_reg;
                                    rx_done <= 1'b1;
                                end
`else
                                rx_data <= shift_reg;
                                rx_done <= 1'b1;
`endif
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_WAIT_HIGH;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed testbench for uart_rx_byte, scaled to 4 clocks per tick (64 clocks per bit).
// Define UART_RX_PARITY_EN to exercise the 8E1 parity variant.
module tb_uart_rx_byte;

    localparam int CLK_FREQ   = 6_400_000;
    localparam int BAUD       = 100_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CLKS = 11 * BIT_CLKS;
`else
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    int n_cmp = 0;
    int n_err = 0;

    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int overlap_cnt = 0;
    int long_cnt = 0;
    int busy_overlap_cnt = 0;
    logic [7:0] cap [16];
    int cap_n = 0;
    logic prev_done = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic flip_parity = 1'b0;
`endif

    uart_rx_byte #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: tallies pulses, captures each delivered byte and notes protocol violations.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_done) begin
                done_cnt++;
                cap[cap_n % 16] = rx_data;
                cap_n++;
            end
            if (frame_err) ferr_cnt++;
            if (parity_err) perr_cnt++;
            if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) overlap_cnt++;
            if ((rx_done && prev_done) || (frame_err && prev_ferr) || (parity_err && prev_perr)) long_cnt++;
            if (rx_done && rx_busy) busy_overlap_cnt++;
        end
        prev_done = rx_done;
        prev_ferr = frame_err;
        prev_perr = parity_err;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame LSB first; the line is left at the stop-bit level afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ flip_parity;
        wait_clks(BIT_CLKS);
`endif
        rx = stop_val;
        wait_clks(BIT_CLKS);
    endtask

    initial begin
        int d0;
        int f0;
        int c0;
        logic [7:0] partial;

        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(5);
        checkOutput("reset_rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset_rx_done", 32'(rx_done), 32'h0);
        checkOutput("reset_rx_busy", 32'(rx_busy), 32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset_parity_err", 32'(parity_err), 32'h0);
        reset = 1'b0;
        wait_clks(20);

        d0 = done_cnt;
        f0 = ferr_cnt;
        applyStimulus(8'h55, 1'b1);
        wait_clks(40);
        checkOutput("x55_done_count", 32'(done_cnt - d0), 32'd1);
        checkOutput("x55_rx_data", 32'(rx_data), 32'h55);
        checkOutput("x55_busy_after", 32'(rx_busy), 32'h0);
        checkOutput("x55_frame_err", 32'(ferr_cnt - f0), 32'd0);

        d0 = done_cnt;
        c0 = cap_n;
        applyStimulus(8'h72, 1'b1);
        applyStimulus(8'h63, 1'b1);
        wait_clks(40);
        checkOutput("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        checkOutput("b2b_first_byte", 32'(cap[c0 % 16]), 32'h72);
        checkOutput("b2b_second_byte", 32'(cap[(c0 + 1) % 16]), 32'h63);
        checkOutput("b2b_rx_data", 32'(rx_data), 32'h63);

        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_clks(12);
        checkOutput("glitch_busy_during", 32'(rx_busy), 32'h1);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        checkOutput("glitch_busy_after", 32'(rx_busy), 32'h0);
        checkOutput("glitch_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("glitch_no_frame_err", 32'(ferr_cnt - f0), 32'd0);
        checkOutput("glitch_rx_data", 32'(rx_data), 32'h63);

        applyStimulus(8'h31, 1'b1);
        wait_clks(40);
        checkOutput("pre_ferr_rx_data", 32'(rx_data), 32'h31);
        d0 = done_cnt;
        f0 = ferr_cnt;
        applyStimulus(8'hA5, 1'b0);
        wait_clks(2 * FRAME_CLKS);
        checkOutput("break_busy_held", 32'(rx_busy), 32'h1);
        checkOutput("break_frame_err_count", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("break_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("break_rx_data_kept", 32'(rx_data), 32'h31);
        rx = 1'b1;
        wait_clks(40);
        checkOutput("break_busy_released", 32'(rx_busy), 32'h0);
        checkOutput("break_frame_err_final", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("break_done_final", 32'(done_cnt - d0), 32'd0);

        d0 = done_cnt;
        partial = 8'h3C;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            wait_clks(BIT_CLKS);
        end
        rx = partial[4];
        wait_clks(BIT_CLKS / 2);
        checkOutput("midframe_busy", 32'(rx_busy), 32'h1);
        reset = 1'b1;
        wait_clks(3);
        checkOutput("midframe_reset_busy", 32'(rx_busy), 32'h0);
        checkOutput("midframe_reset_data", 32'(rx_data), 32'h00);
        reset = 1'b0;
        rx    = 1'b1;
        wait_clks(FRAME_CLKS);
        checkOutput("midframe_no_done", 32'(done_cnt - d0), 32'd0);
        applyStimulus(8'h31, 1'b1);
        wait_clks(40);
        checkOutput("after_reset_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("after_reset_rx_data", 32'(rx_data), 32'h31);

`ifdef UART_RX_PARITY_EN
        d0 = done_cnt;
        f0 = perr_cnt;
        flip_parity = 1'b0;
        applyStimulus(8'h07, 1'b1);
        wait_clks(40);
        checkOutput("par_good_done", 32'(done_cnt - d0), 32'd1);
        checkOutput("par_good_rx_data", 32'(rx_data), 32'h07);
        checkOutput("par_good_no_perr", 32'(perr_cnt - f0), 32'd0);
        d0 = done_cnt;
        flip_parity = 1'b1;
        applyStimulus(8'h5A, 1'b1);
        flip_parity = 1'b0;
        wait_clks(40);
        checkOutput("par_bad_perr", 32'(perr_cnt - f0), 32'd1);
        checkOutput("par_bad_no_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("par_bad_rx_data", 32'(rx_data), 32'h07);
        checkOutput("par_bad_busy", 32'(rx_busy), 32'h0);
        checkOutput("total_parity_err", 32'(perr_cnt), 32'd1);
`else
        checkOutput("total_parity_err", 32'(perr_cnt), 32'd0);
`endif

        checkOutput("strobe_overlap", 32'(overlap_cnt), 32'd0);
        checkOutput("strobe_too_long", 32'(long_cnt), 32'd0);
        checkOutput("busy_with_done", 32'(busy_overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
